event_arb_ctrl: RTL and testbench

EVENT_ARB_CTRL -- requirements
Module: event_arb_ctrl

---
 rtl/event_arb_ctrl.sv | 117 +++++++++++
 tb/tb_event_arb_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/event_arb_ctrl.sv
// event_arb_ctrl: round-robin burst arbiter. N request ports share one output stream.
// A grant is held until the port sends its last beat, reaches MAX_BURST beats, or
// drops its request. After a release there is always at least one IDLE cycle.
module event_arb_ctrl #(
    parameter  int NUM_PORTS = 4,
    parameter  int DATA_W    = 16,
    parameter  int MAX_BURST = 8,
    localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS*DATA_W-1:0] data_i,
    input  logic [NUM_PORTS-1:0]        last_i,
    output logic [NUM_PORTS-1:0]        rdy_o,
    output logic                        out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    output logic                        out_last_o,
    output logic [PW-1:0]               out_port_o,
    input  logic                        out_ready_i,
    output logic [NUM_PORTS-1:0]        gnt_o,
    output logic                        busy_o
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_PORTS-1:0] r_gnt,   w_gnt_nxt;
    logic [PW-1:0]        r_port,  w_port_nxt;
    logic [PW-1:0]        r_ptr,   w_ptr_nxt;
    logic [7:0]           r_cnt,   w_cnt_nxt;

    logic                 w_found;
    logic [PW-1:0]        w_win;
    logic                 w_req_g, w_last_g, w_busy, w_xfer;
    logic [DATA_W-1:0]    w_data_g;
    logic [7:0]           w_cnt_inc;

    // Signals of the currently granted port (r_port is 0 in IDLE, gated below)
    assign w_req_g   = req_i[r_port];
    assign w_last_g  = last_i[r_port];
    assign w_data_g  = data_i[r_port*DATA_W +: DATA_W];
    assign w_busy    = (r_state == GRANT);
    assign w_xfer    = w_busy & w_req_g & out_ready_i;
    assign w_cnt_inc = r_cnt + 8'd1;

    assign busy_o      = w_busy;
    assign gnt_o       = r_gnt;
    assign out_port_o  = r_port;
    assign out_valid_o = w_busy & w_req_g;
    assign out_last_o  = w_busy & w_last_g;
    assign out_data_o  = w_busy ? w_data_g : '0;
    assign rdy_o       = w_xfer ? r_gnt : '0;

    // Round-robin search: first requester at or above r_ptr, wrapping to 0
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && req_i[(int'(r_ptr) + k) % NUM_PORTS]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_ptr) + k) % NUM_PORTS);
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and decide release in GRANT
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_port_nxt  = r_port;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt       = GRANT;
                    w_gnt_nxt         = '0;
                    w_gnt_nxt[w_win]  = 1'b1;
                    w_port_nxt        = w_win;
                    w_cnt_nxt         = 8'd0;
                end
            end
            GRANT: begin
                if (w_xfer)
                    w_cnt_nxt = w_cnt_inc;
                // Withdrawal, last beat, or burst limit all release identically
                if (!w_req_g || (w_xfer && (w_last_g || (w_cnt_inc == 8'(MAX_BURST))))) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_port_nxt  = '0;
                    w_cnt_nxt   = 8'd0;
                    w_ptr_nxt   = (int'(r_port) == NUM_PORTS - 1) ? '0 : r_port + PW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with asynchronous clear
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_port  <= '0;
            r_ptr   <= '0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_port  <= w_port_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_event_arb_ctrl.sv
// Bench for event_arb_ctrl: a spec-level model (granted port, beat count, pointer)
// is compared with the DUT every cycle; directed scenarios add literal checks.
module tb_event_arb_ctrl;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req, last, rdy, gnt;
    logic [N*DW-1:0] data;
    logic            ready, ov, ol, busy;
    logic [DW-1:0]   od;
    logic [1:0]      op;

    event_arb_ctrl #(.NUM_PORTS(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_i(req), .data_i(data), .last_i(last),
        .rdy_o(rdy), .out_valid_o(ov), .out_data_o(od), .out_last_o(ol),
        .out_port_o(op), .out_ready_i(ready), .gnt_o(gnt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int mg, mcnt, mptr;           // model: granted port (-1 = none), beats, pointer
    int seq[N], xcnt[N], loss[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Each port's data is {port, sequence number}; the sequence advances only on acceptance
    task automatic drive_data();
        for (int i = 0; i < N; i++)
            data[i*DW +: DW] = 16'((i << 12) | (seq[i] & 'hfff));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req = '0; last = '0; ready = 1'b0;
        mg = -1; mcnt = 0; mptr = 0;
        for (int i = 0; i < N; i++) begin xcnt[i] = 0; loss[i] = 0; end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One clock: compare at the falling edge, advance the model after the rising edge
    task automatic cyc();
        logic [N-1:0]  e_gnt, e_rdy;
        logic          e_v, e_l, e_b;
        logic [DW-1:0] e_d;
        logic [1:0]    e_p;
        int nmg, nmcnt, nptr, w;
        @(negedge clk);
        e_gnt = '0; e_rdy = '0; e_v = 0; e_l = 0; e_b = 0; e_d = '0; e_p = '0;
        nmg = mg; nmcnt = mcnt; nptr = mptr;
        if (mg < 0) begin
            if (req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
                for (int i = 0; i < N; i++) begin
                    if (req[i] && i != w) begin
                        loss[i]++;
                        chk("starvation", 64'(loss[i] < N), 64'd1);
                    end else loss[i] = 0;
                end
                nmg = w; nmcnt = 0;
            end
        end else begin
            e_gnt = N'(1 << mg); e_b = 1'b1; e_p = 2'(mg);
            e_v = req[mg]; e_l = last[mg]; e_d = data[mg*DW +: DW];
            if (req[mg] && ready) begin
                e_rdy = N'(1 << mg);
                nmcnt = mcnt + 1;
                xcnt[mg]++;
            end
            if (!req[mg] || (req[mg] && ready && (last[mg] || nmcnt == MB))) begin
                nmg = -1; nmcnt = 0; nptr = (mg + 1) % N;
            end
        end
        chk("outputs {gnt,rdy,valid,data,last,port,busy}",
            {35'd0, gnt, rdy, ov, od, ol, op, busy},
            {35'd0, e_gnt, e_rdy, e_v, e_d, e_l, e_p, e_b});
        chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
        @(posedge clk); #1;
        mg = nmg; mcnt = nmcnt; mptr = nptr;
        for (int i = 0; i < N; i++) if (e_rdy[i]) seq[i]++;
        drive_data();
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 1;
        drive_data();
        apply_reset();
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_busy_valid_port", 64'({busy, ov, op}), 64'd0);

        // Port 1 sends a single last beat, then port 3 wins from ptr=2
        req = 4'b1010; last = 4'b0010; ready = 1'b1;
        cyc();
        chk("t1_gnt_port1", 64'(gnt), 64'b0010);
        chk("t1_port", 64'(op), 64'd1);
        cyc();
        chk("t1_released", 64'({gnt, busy}), 64'd0);
        chk("t1_beats", 64'(xcnt[1]), 64'd1);
        cyc();
        chk("t1_next_port3", 64'(gnt), 64'b1000);

        // Full bursts in round-robin order with an IDLE gap
        apply_reset();
        req = 4'b1111; last = '0; ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t2_gnt_order", 64'(gnt), 64'(1 << (k % 4)));
            repeat (MB) cyc();
            chk("t2_release_after_burst", 64'(busy), 64'd0);
        end
        chk("t2_beats_p0", 64'(xcnt[0]), 64'd16);
        for (int i = 1; i < N; i++) chk("t2_beats_pN", 64'(xcnt[i]), 64'd8);

        // Downstream stall holds the grant without counting beats
        apply_reset();
        req = 4'b0100; ready = 1'b0;
        cyc();
        chk("t3_gnt_port2", 64'(gnt), 64'b0100);
        repeat (5) cyc();
        chk("t3_held", 64'({gnt, busy}), 64'b01001);
        chk("t3_no_beats", 64'(xcnt[2]), 64'd0);
        ready = 1'b1;
        cyc();
        chk("t3_first_beat_cycle6", 64'(xcnt[2]), 64'd1);

        // Withdrawal after three beats
        apply_reset();
        req = 4'b0001; ready = 1'b1;
        cyc();
        repeat (3) cyc();
        chk("t4_three_beats", 64'(xcnt[0]), 64'd3);
        chk("t4_still_busy", 64'(busy), 64'd1);
        req = '0;
        cyc();
        chk("t4_released", 64'({gnt, busy}), 64'd0);
        req = 4'b0011;
        cyc();
        chk("t4_ptr1_wins", 64'(gnt), 64'b0010);

        // Asynchronous reset in the middle of a burst on port 3
        apply_reset();
        req = 4'b1000; ready = 1'b1;
        cyc();
        repeat (4) cyc();
        chk("t5_four_beats", 64'(xcnt[3]), 64'd4);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_clear", 64'({gnt, rdy, ov, od, ol, op, busy}), 64'd0);
        apply_reset();
        req = 4'b1001; ready = 1'b1;
        cyc();
        chk("t5_port0_after_reset", 64'(gnt), 64'b0001);

        // Random traffic
        apply_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i]  = ($urandom_range(0, 7) != 0);
                last[i] = ($urandom_range(0, 5) == 0);
            end
            ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
